// File: rtl/dm_pkg.sv
// Shared definitions for the debug-memory arbiter: response owner encoding and read latency.
package dm_pkg;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    localparam int RespLatency = 1;

endpackage

// File: rtl/dm_arb_select.sv
// Combinational grant selection between the instruction and data ports of the debug memory.
module dm_arb_select
    import dm_pkg::*;
(
    input  logic   ireq,
    input  logic   dreq,
    input  logic   hold,
    input  owner_e ptr,
    input  logic   starve,
    output logic   igrant,
    output logic   dgrant
);

    logic prefer_instr;

    // A contested cycle goes to the instruction port when it is starved or the pointer favours it.
    assign prefer_instr = starve | (ptr == OWNER_INSTR);

    assign igrant = ~hold & ireq & (~dreq | prefer_instr);
    assign dgrant = ~hold & dreq & (~ireq | ~prefer_instr);

endmodule

// File: rtl/dm_mem_arbiter.sv
// Arbitrates instruction and data requests onto one debug-memory port with a 1-cycle read latency.
// Define DM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise data has priority with a starvation bound.
module dm_mem_arbiter
    import dm_pkg::*;
#(
    parameter int BusWidth = 32,
    parameter int MaxWait  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  ireq_i,
    input  logic [BusWidth-1:0]   iaddr_i,
    output logic                  igrant_o,
    output logic                  irvalid_o,
    output logic [BusWidth-1:0]   irdata_o,
    input  logic                  dreq_i,
    input  logic                  dwe_i,
    input  logic [BusWidth-1:0]   daddr_i,
    input  logic [BusWidth-1:0]   dwdata_i,
    input  logic [BusWidth/8-1:0] dbe_i,
    output logic                  dgrant_o,
    output logic                  drvalid_o,
    output logic [BusWidth-1:0]   drdata_o,
    output logic                  req_o,
    output logic                  we_o,
    output logic [BusWidth-1:0]   addr_o,
    output logic [BusWidth-1:0]   wdata_o,
    output logic [BusWidth/8-1:0] be_o,
    input  logic [BusWidth-1:0]   rdata_i
);

    localparam int BeWidth = BusWidth / 8;

    logic                   igrant;
    logic                   dgrant;
    logic                   any_grant;
    logic                   starve;
    logic                   rsp_valid;
    owner_e                 rr_ptr;
    owner_e                 owner_q;
    logic [RespLatency-1:0] valid_q;

    // Reset and flush both block new address phases immediately.
    dm_arb_select u_select (
        .ireq   (ireq_i),
        .dreq   (dreq_i),
        .hold   (flush_i | ~rst_ni),
        .ptr    (rr_ptr),
        .starve (starve),
        .igrant (igrant),
        .dgrant (dgrant)
    );

    assign any_grant = igrant | dgrant;

`ifdef DM_ARB_ROUND_ROBIN_EN
    owner_e rr_ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= OWNER_DATA;
        end else if (flush_i) begin
            rr_ptr_q <= OWNER_DATA;
        end else if (ireq_i && dreq_i) begin
            rr_ptr_q <= igrant ? OWNER_DATA : OWNER_INSTR;
        end
    end

    assign rr_ptr = rr_ptr_q;
    assign starve = 1'b0;
`else
    localparam int                  CntWidth = $clog2(MaxWait + 1);
    localparam logic [CntWidth-1:0] CntMax   = CntWidth'(MaxWait);

    logic [CntWidth-1:0] wait_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt <= '0;
        end else if (flush_i || igrant) begin
            wait_cnt <= '0;
        end else if (ireq_i && (wait_cnt != CntMax)) begin
            wait_cnt <= wait_cnt + CntWidth'(1);
        end
    end

    assign rr_ptr = OWNER_DATA;
    assign starve = (wait_cnt == CntMax);
`endif

    // Response phase: remember who owns the beat returning next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            owner_q <= OWNER_INSTR;
        end else if (flush_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= RespLatency'(any_grant);
            if (any_grant) begin
                owner_q <= dgrant ? OWNER_DATA : OWNER_INSTR;
            end
        end
    end

    assign rsp_valid = valid_q[RespLatency-1];

    assign igrant_o  = igrant;
    assign dgrant_o  = dgrant;
    assign req_o     = any_grant;
    assign irvalid_o = rsp_valid & (owner_q == OWNER_INSTR);
    assign drvalid_o = rsp_valid & (owner_q == OWNER_DATA);
    assign irdata_o  = irvalid_o ? rdata_i : '0;
    assign drdata_o  = drvalid_o ? rdata_i : '0;

    assign we_o    = dgrant & dwe_i;
    assign addr_o  = dgrant ? daddr_i : (igrant ? iaddr_i : '0);
    assign wdata_o = dgrant ? dwdata_i : '0;
    assign be_o    = dgrant ? dbe_i : (igrant ? {BeWidth{1'b1}} : '0);

endmodule

// File: tb/tb_dm_mem_arbiter.sv
// Self-checking bench for dm_mem_arbiter; follows DM_ARB_ROUND_ROBIN_EN to pick the arbitration expectations.
module tb_dm_mem_arbiter;

    localparam int BW = 32;
    localparam int MW = 4;
    localparam logic [BW/8-1:0] BE_ALL = '1;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b1;
    logic            flush_i;
    logic            ireq_i;
    logic [BW-1:0]   iaddr_i;
    logic            igrant_o;
    logic            irvalid_o;
    logic [BW-1:0]   irdata_o;
    logic            dreq_i;
    logic            dwe_i;
    logic [BW-1:0]   daddr_i;
    logic [BW-1:0]   dwdata_i;
    logic [BW/8-1:0] dbe_i;
    logic            dgrant_o;
    logic            drvalid_o;
    logic [BW-1:0]   drdata_o;
    logic            req_o;
    logic            we_o;
    logic [BW-1:0]   addr_o;
    logic [BW-1:0]   wdata_o;
    logic [BW/8-1:0] be_o;
    logic [BW-1:0]   rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected responses, one per grant: {valid, is_data, is_write}.
    logic [2:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    dm_mem_arbiter #(.BusWidth(BW), .MaxWait(MW)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .flush_i   (flush_i),
        .ireq_i    (ireq_i),
        .iaddr_i   (iaddr_i),
        .igrant_o  (igrant_o),
        .irvalid_o (irvalid_o),
        .irdata_o  (irdata_o),
        .dreq_i    (dreq_i),
        .dwe_i     (dwe_i),
        .daddr_i   (daddr_i),
        .dwdata_i  (dwdata_i),
        .dbe_i     (dbe_i),
        .dgrant_o  (dgrant_o),
        .drvalid_o (drvalid_o),
        .drdata_o  (drdata_o),
        .req_o     (req_o),
        .we_o      (we_o),
        .addr_o    (addr_o),
        .wdata_o   (wdata_o),
        .be_o      (be_o),
        .rdata_i   (rdata_i)
    );

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        flush_i  = 1'b0;
        ireq_i   = 1'b0;
        iaddr_i  = '0;
        dreq_i   = 1'b0;
        dwe_i    = 1'b0;
        daddr_i  = '0;
        dwdata_i = '0;
        dbe_i    = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    function automatic logic [2:0] pop_exp();
        if (exp_q.size() == 0) return 3'b000;
        return exp_q.pop_front();
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [BW-1:0] rd;
        rd = 32'hA5A5_0F0F;
        rst_ni = 1'b0;
        drive_idle();
        ireq_i = 1'b1; iaddr_i = 32'h800;
        dreq_i = 1'b1; dwe_i = 1'b1; daddr_i = 32'h380; dwdata_i = 32'h1234_5678; dbe_i = 4'hF;
        rdata_i = rd;
        next_cycle();
        next_cycle();
        settle();
        n_tests++;
        if ({igrant_o, dgrant_o, req_o, irvalid_o, drvalid_o} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_ctrl: grant/req/rvalid=%b expected 00000",
                     {igrant_o, dgrant_o, req_o, irvalid_o, drvalid_o});
        end
        n_tests++;
        if (irdata_o !== '0 || drdata_o !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: irdata=%h drdata=%h expected 0", irdata_o, drdata_o);
        end
        n_tests++;
        if (we_o !== 1'b0 || addr_o !== '0 || wdata_o !== '0 || be_o !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: we=%b addr=%h wdata=%h be=%h expected 0", we_o, addr_o, wdata_o, be_o);
        end
        #1;
        rst_ni = 1'b1;
        drive_idle();
        next_cycle();
        settle();
        n_tests++;
        if (irvalid_o !== 1'b0 || drvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: irvalid=%b drvalid=%b expected 0 0", irvalid_o, drvalid_o);
        end
        next_cycle();
    endtask

    task automatic test_instr_read();
        logic [2:0]    e;
        logic [BW-1:0] rd;
        drive_idle();
        ireq_i  = 1'b1;
        iaddr_i = 32'h800;
        rdata_i = 32'h5555_AAAA;
        settle();
        n_tests++;
        if ({igrant_o, dgrant_o, req_o} !== 3'b101) begin
            n_fail++;
            $display("FAIL ird_grant: igrant/dgrant/req=%b expected 101", {igrant_o, dgrant_o, req_o});
        end
        n_tests++;
        if (addr_o !== 32'h800 || we_o !== 1'b0 || be_o !== BE_ALL) begin
            n_fail++;
            $display("FAIL ird_bus: addr=%h we=%b be=%h expected 800 0 %h", addr_o, we_o, be_o, BE_ALL);
        end
        exp_q.push_back(3'b100);
        next_cycle();
        drive_idle();
        rd = 32'h0180_006F;
        rdata_i = rd;
        settle();
        e = pop_exp();
        n_tests++;
        if (irvalid_o !== (e[2] & ~e[1]) || drvalid_o !== (e[2] & e[1])) begin
            n_fail++;
            $display("FAIL ird_rvalid: irvalid=%b drvalid=%b expected %b %b",
                     irvalid_o, drvalid_o, e[2] & ~e[1], e[2] & e[1]);
        end
        n_tests++;
        if (irdata_o !== ((e[2] & ~e[1]) ? rd : '0)) begin
            n_fail++;
            $display("FAIL ird_rdata: irdata=%h expected %h", irdata_o, rd);
        end
        next_cycle();
    endtask

    task automatic test_data_write();
        logic [2:0] e;
        drive_idle();
        dreq_i = 1'b1; dwe_i = 1'b1; daddr_i = 32'h380; dwdata_i = 32'hDEAD_BEEF; dbe_i = 4'hF;
        rdata_i = 32'h0BAD_F00D;
        settle();
        n_tests++;
        if ({igrant_o, dgrant_o, req_o, we_o} !== 4'b0111) begin
            n_fail++;
            $display("FAIL dwr_grant: igrant/dgrant/req/we=%b expected 0111", {igrant_o, dgrant_o, req_o, we_o});
        end
        n_tests++;
        if (wdata_o !== 32'hDEAD_BEEF || addr_o !== 32'h380 || be_o !== 4'hF) begin
            n_fail++;
            $display("FAIL dwr_bus: wdata=%h addr=%h be=%h expected deadbeef 380 f", wdata_o, addr_o, be_o);
        end
        exp_q.push_back(3'b111);
        next_cycle();
        drive_idle();
        settle();
        e = pop_exp();
        n_tests++;
        if (drvalid_o !== (e[2] & e[1]) || irvalid_o !== (e[2] & ~e[1]) || irdata_o !== '0) begin
            n_fail++;
            $display("FAIL dwr_ack: drvalid=%b irvalid=%b irdata=%h expected %b %b 0",
                     drvalid_o, irvalid_o, irdata_o, e[2] & e[1], e[2] & ~e[1]);
        end
        next_cycle();
    endtask

    task automatic test_priority();
        logic [2:0]    e;
        logic [BW-1:0] rd;
        logic          exp_dg;
        int            n_cyc;
`ifdef DM_ARB_ROUND_ROBIN_EN
        n_cyc = 6;
`else
        n_cyc = 10;
`endif
        for (int i = 0; i <= n_cyc; i++) begin
            drive_idle();
            rd = $urandom;
            rdata_i = rd;
            if (i < n_cyc) begin
                ireq_i = 1'b1; iaddr_i = 32'h800 + 32'(i * 4);
                dreq_i = 1'b1; daddr_i = 32'h300 + 32'(i * 4);
            end
`ifdef DM_ARB_ROUND_ROBIN_EN
            exp_dg = (i % 2) == 0;
`else
            exp_dg = !((i % (MW + 1)) == MW);
`endif
            settle();
            e = pop_exp();
            if (i < n_cyc) begin
                n_tests++;
                if ({igrant_o, dgrant_o} !== {~exp_dg, exp_dg}) begin
                    n_fail++;
                    $display("FAIL prio_grant[%0d]: igrant/dgrant=%b expected %b", i,
                             {igrant_o, dgrant_o}, {~exp_dg, exp_dg});
                end
                n_tests++;
                if (addr_o !== (exp_dg ? daddr_i : iaddr_i)) begin
                    n_fail++;
                    $display("FAIL prio_addr[%0d]: addr=%h expected %h", i, addr_o, exp_dg ? daddr_i : iaddr_i);
                end
                exp_q.push_back({1'b1, exp_dg, 1'b0});
            end
            n_tests++;
            if (irvalid_o !== (e[2] & ~e[1]) || drvalid_o !== (e[2] & e[1]) ||
                irdata_o !== ((e[2] & ~e[1]) ? rd : '0) || drdata_o !== ((e[2] & e[1]) ? rd : '0)) begin
                n_fail++;
                $display("FAIL prio_resp[%0d]: irv=%b drv=%b ird=%h drd=%h expected irv=%b drv=%b data=%h",
                         i, irvalid_o, drvalid_o, irdata_o, drdata_o, e[2] & ~e[1], e[2] & e[1], rd);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]      e;
        logic [BW-1:0]   a, w, rd;
        logic [BW/8-1:0] b;
        logic            ig, dg, wr;
        int              kind;
        for (int i = 0; i <= 40; i++) begin
            kind = (i == 40) ? 0 : int'($urandom_range(0, 3));
            a  = $urandom; w = $urandom; rd = $urandom;
            b  = 4'($urandom_range(0, 15));
            ig = (kind == 1);
            dg = (kind >= 2);
            wr = (kind == 3);
            drive_idle();
            rdata_i = rd;
            ireq_i = ig; iaddr_i = a;
            dreq_i = dg; dwe_i = wr; daddr_i = a; dwdata_i = w; dbe_i = b;
            settle();
            e = pop_exp();
            n_tests++;
            if ({igrant_o, dgrant_o, req_o} !== {ig, dg, ig | dg}) begin
                n_fail++;
                $display("FAIL b2b_grant[%0d]: igrant/dgrant/req=%b expected %b", i,
                         {igrant_o, dgrant_o, req_o}, {ig, dg, ig | dg});
            end
            if (dg) begin
                n_tests++;
                if (addr_o !== a || we_o !== wr || wdata_o !== w || be_o !== b) begin
                    n_fail++;
                    $display("FAIL b2b_dbus[%0d]: addr=%h we=%b wdata=%h be=%h expected %h %b %h %h",
                             i, addr_o, we_o, wdata_o, be_o, a, wr, w, b);
                end
            end
            if (ig) begin
                n_tests++;
                if (addr_o !== a || we_o !== 1'b0 || be_o !== BE_ALL) begin
                    n_fail++;
                    $display("FAIL b2b_ibus[%0d]: addr=%h we=%b be=%h expected %h 0 %h", i, addr_o, we_o, be_o, a, BE_ALL);
                end
            end
            n_tests++;
            if (irvalid_o !== (e[2] & ~e[1]) || drvalid_o !== (e[2] & e[1]) ||
                irdata_o !== ((e[2] & ~e[1]) ? rd : '0)) begin
                n_fail++;
                $display("FAIL b2b_resp[%0d]: irv=%b drv=%b ird=%h expected %b %b %h", i,
                         irvalid_o, drvalid_o, irdata_o, e[2] & ~e[1], e[2] & e[1], (e[2] & ~e[1]) ? rd : '0);
            end
            if (!(e[2] & e[1] & e[0])) begin
                n_tests++;
                if (drdata_o !== ((e[2] & e[1]) ? rd : '0)) begin
                    n_fail++;
                    $display("FAIL b2b_drdata[%0d]: drdata=%h expected %h", i, drdata_o, (e[2] & e[1]) ? rd : '0);
                end
            end
            if (ig | dg) exp_q.push_back({1'b1, dg, wr});
            next_cycle();
        end
    endtask

    task automatic test_flush();
        logic [2:0] e;
        int         n_pre, n_post;
        logic       exp_dg;
        // Data read, then flush with both ports requesting.
        drive_idle();
        dreq_i = 1'b1; daddr_i = 32'h40;
        rdata_i = 32'h1111_2222;
        settle();
        n_tests++;
        if (dgrant_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pregrant: dgrant=%b expected 1", dgrant_o);
        end
        exp_q.push_back(3'b110);
        next_cycle();
        flush_i = 1'b1; ireq_i = 1'b1; iaddr_i = 32'h800;
        settle();
        e = pop_exp();
        n_tests++;
        if ({igrant_o, dgrant_o, req_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_nogrant: igrant/dgrant/req=%b expected 000", {igrant_o, dgrant_o, req_o});
        end
        next_cycle();
        drive_idle();
        settle();
        n_tests++;
        if (drvalid_o !== 1'b0 || irvalid_o !== 1'b0 || drdata_o !== '0) begin
            n_fail++;
            $display("FAIL flush_norsp: drvalid=%b irvalid=%b drdata=%h expected 0 0 0", drvalid_o, irvalid_o, drdata_o);
        end
        next_cycle();
        // Contention, flush, contention: arbitration state must restart from reset.
`ifdef DM_ARB_ROUND_ROBIN_EN
        n_pre = 1; n_post = 2;
`else
        n_pre = 3; n_post = MW + 1;
`endif
        for (int i = 0; i < n_pre + 1 + n_post; i++) begin
            drive_idle();
            ireq_i = 1'b1; iaddr_i = 32'h804;
            dreq_i = 1'b1; daddr_i = 32'h304;
            flush_i = (i == n_pre);
            if (i == n_pre)     exp_dg = 1'b0;
            else if (i < n_pre) exp_dg = 1'b1;
            else                exp_dg = (i - n_pre - 1) != (n_post - 1);
            settle();
            n_tests++;
            if ({igrant_o, dgrant_o} !== {~exp_dg & (i != n_pre), exp_dg}) begin
                n_fail++;
                $display("FAIL flush_arb[%0d]: igrant/dgrant=%b expected %b", i,
                         {igrant_o, dgrant_o}, {~exp_dg & (i != n_pre), exp_dg});
            end
            next_cycle();
        end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        drive_idle();
        ireq_i = 1'b1; iaddr_i = 32'h900;
        rdata_i = 32'hCAFE_0001;
        settle();
        n_tests++;
        if (igrant_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_grant: igrant=%b expected 1", igrant_o);
        end
        #1;
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if ({igrant_o, dgrant_o, req_o, irvalid_o, drvalid_o} !== 5'b00000 || addr_o !== '0) begin
            n_fail++;
            $display("FAIL rmid_assert: ctrl=%b addr=%h expected 00000 0",
                     {igrant_o, dgrant_o, req_o, irvalid_o, drvalid_o}, addr_o);
        end
        next_cycle();
        settle();
        n_tests++;
        if (irvalid_o !== 1'b0 || irdata_o !== '0 || igrant_o !== 1'b0 || be_o !== '0) begin
            n_fail++;
            $display("FAIL rmid_hold: irvalid=%b irdata=%h igrant=%b be=%h expected 0", irvalid_o, irdata_o, igrant_o, be_o);
        end
        #1;
        rst_ni = 1'b1;
        drive_idle();
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            settle();
            n_tests++;
            if (irvalid_o !== 1'b0 || drvalid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_release[%0d]: irvalid=%b drvalid=%b expected 0 0", i, irvalid_o, drvalid_o);
            end
        end
        next_cycle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        drive_idle();
        rdata_i = '0;
        rst_ni  = 1'b0;
        test_reset();
        test_instr_read();
        test_data_write();
        test_priority();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dm_mem_arbiter.md
DM_MEM_ARBITER -- requirements
Module: dm_mem_arbiter

Interface
REQ-001 The block SHALL have parameter BusWidth, default 32, giving the address and data width of all ports.
REQ-002 The block SHALL have parameter MaxWait, default 4, giving the maximum number of cycles a pending instruction request may be bypassed in fixed-priority mode.
REQ-003 The block SHALL have port clk_i, input, 1, the only clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_ni, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port flush_i, input, 1, which aborts response tracking; it is driven from ndmreset.
REQ-006 The block SHALL have instruction-port inputs ireq_i (1) and iaddr_i (BusWidth); this port is read-only.
REQ-007 The block SHALL have instruction-port outputs igrant_o (1), irvalid_o (1) and irdata_o (BusWidth).
REQ-008 The block SHALL have data-port inputs dreq_i (1), dwe_i (1), daddr_i (BusWidth), dwdata_i (BusWidth) and dbe_i (BusWidth/8).
REQ-009 The block SHALL have data-port outputs dgrant_o (1), drvalid_o (1) and drdata_o (BusWidth).
REQ-010 The block SHALL have debug-memory-side outputs req_o (1), we_o (1), addr_o, wdata_o and be_o, and input rdata_i (BusWidth) with fixed 1-cycle read latency.

Function
REQ-011 A requester SHALL hold its request and payload stable until its grant is asserted; grant and request sampled high in the same cycle completes the address phase.
REQ-012 At most one grant SHALL be asserted per cycle, and req_o SHALL equal igrant_o OR dgrant_o, combinationally, in the same cycle.
REQ-013 addr_o, we_o, wdata_o and be_o SHALL be muxed from the granted port; for an instruction grant, we_o=0 and be_o is all ones.
REQ-014 For a grant with we=0, the matching rvalid SHALL pulse exactly one cycle after the grant, with rdata equal to rdata_i; the non-owning port's rvalid SHALL be 0.
REQ-015 For a data write, drvalid_o SHALL pulse one cycle after the grant as a write acknowledge, with drdata_o don't-care.
REQ-016 Back-to-back grants SHALL be allowed every cycle, with no bubble between transactions.
REQ-017 Response ownership SHALL be tracked in owner_q (INSTR/DATA) and valid_q registers, which form the response-phase state.
REQ-018 When only one port requests, that port SHALL be granted in the same cycle.
REQ-019 When flush_i is asserted, no grant SHALL be issued, valid_q SHALL clear so that no rvalid is produced the next cycle, and the starvation counter and round-robin pointer SHALL return to their reset values.
REQ-020 flush_i asserted in the same cycle as a request SHALL take precedence over the request.
REQ-021 Each rdata output SHALL be gated to zero when its rvalid is 0.

Reset
REQ-022 While rst_ni=0, all grant, rvalid and req_o outputs SHALL be 0, rdata outputs SHALL be 0, valid_q SHALL be 0, owner_q SHALL be INSTR, wait_cnt SHALL be 0 and the round-robin pointer SHALL point to DATA.
REQ-023 A reset asserted mid-transaction SHALL drop the pending response; no rvalid is produced after reset release.

Configuration
REQ-024 With macro DM_ARB_ROUND_ROBIN_EN defined, on simultaneous requests the port not most recently granted SHALL win; the pointer updates only on a contested grant.
REQ-025 Without DM_ARB_ROUND_ROBIN_EN, the data port SHALL have fixed priority.
REQ-026 Without the macro, wait_cnt (width $clog2(MaxWait+1)) SHALL increment each cycle ireq_i is high and not granted, and clear when the instruction port is granted.
REQ-027 Without the macro, when wait_cnt equals MaxWait the instruction port SHALL win the next contested cycle.
REQ-028 With the macro defined, wait_cnt SHALL not exist, and MaxWait SHALL be accepted but unused.

Structure
REQ-029 The owner encoding (INSTR=0, DATA=1) and the response-latency constant (1) SHALL reside in shared package dm_pkg.
REQ-030 Grant selection SHALL be a sub-module dm_arb_select, purely combinational, taking request, pointer and starvation inputs; dm_mem_arbiter holds all registers.

Verification
REQ-031 Single instruction read: ireq_i=1 with iaddr_i=0x800 and rdata_i=0x0180006F the next cycle -> igrant_o=1 in cycle 0; irvalid_o=1 with irdata_o=0x0180006F in cycle 1; drvalid_o=0.
REQ-032 Data write: dreq_i=1, dwe_i=1, daddr_i=0x380, dwdata_i=0xDEADBEEF, dbe_i=0xF -> same-cycle req_o=1, we_o=1, wdata_o=0xDEADBEEF; drvalid_o=1 in the next cycle.
REQ-033 Fixed priority with MaxWait=4, both requesters held high -> data granted for cycles 0-3; instruction granted in cycle 4; wait_cnt returns to 0.
REQ-034 DM_ARB_ROUND_ROBIN_EN defined, both requesters held high for 6 cycles -> grants alternate D,I,D,I,D,I.
REQ-035 flush_i=1 in the cycle after a data read grant -> drvalid_o=0 in the following cycle, and no grant in the flush cycle.
REQ-036 rst_ni pulsed low during a pending instruction read -> irvalid_o stays 0, and all outputs read 0 during reset.
